hvac_actuator: RTL and testbench
================================

# hvac_actuator

Converts the 2-bit thermostat status (0 idle, 1 heat, 2 cool, 3 error) into registered drive signals for the heater relay, cooler relay and circulation fan. Sits directly downstream of the thermostat comparator. Debounces status changes, enforces minimum run and rest times to protect the compressor and relays, and forces a safe all-off fault state whenever status reports an error.

## Interface
- CLK_HZ, 50_000_000: clock cycles per one-second tick
- STABLE_S, 3: seconds a status value must hold before it is accepted (1..15)
- MIN_ON_S, 60: minimum seconds in HEAT or COOL before leaving (1..255)
- MIN_OFF_S, 120: seconds all actuators stay off in REST (1..255)
- FAN_PURGE_S, 30: seconds the fan keeps running at the start of REST after HEAT/COOL (0..MIN_OFF_S)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- status  in  2  thermostat status; not assumed to be synchronised or glitch-free
- heater_on  out  1  heater relay drive
- cooler_on  out  1  cooler relay drive
- fan_on  out  1  circulation fan drive
- fault  out  1  high while in FAULT
- state_out  out  3  current FSM state code

## Operation
- Prescaler counts 0..CLK_HZ-1; a one-cycle `tick` fires on wrap. All second counters advance only on `tick`.
- Debouncer: candidate register plus stable counter. If status ≠ candidate: candidate ← status, counter ← 0. Otherwise, on tick, counter increments, saturating at STABLE_S. When counter == STABLE_S, filt ← candidate.
- Error bypass: raw status == 3 on any clock edge forces FAULT on that edge. This overrides debounce, minimum run time and rest.
- States: IDLE=0, HEAT=1, COOL=2, REST=3, FAULT=4.
- Outputs per state:
  - IDLE: all outputs 0.
  - HEAT: heater_on=1, fan_on=1.
  - COOL: cooler_on=1, fan_on=1.
  - REST: fan_on = purge && rest_cnt < FAN_PURGE_S; the other outputs are 0.
  - FAULT: fault=1; all other outputs are 0.
- Transitions:
  - IDLE: filt==1 → HEAT; filt==2 → COOL. run_cnt ← 0 on entry.
  - HEAT/COOL: run_cnt increments on tick, saturating at MIN_ON_S. Exit to REST when run_cnt == MIN_ON_S and filt ≠ the state's own code. On entry to REST: purge ← 1, rest_cnt ← 0.
  - There is no direct HEAT↔COOL transition. The path is always through REST and IDLE.
  - REST: rest_cnt increments on tick. At rest_cnt == MIN_OFF_S → IDLE.
  - FAULT: see Configuration. Exit is always to REST with purge ← 0 and rest_cnt ← 0.
- Reset: state ← REST, purge ← 0, all counters 0, filt ← 0, candidate ← 0. The block enforces a full MIN_OFF_S rest after power-up.
- Invariant: heater_on && cooler_on is never 1.

## Timing
- Reset values: heater_on=0, cooler_on=0, fan_on=0, fault=0, state_out=3.
- State and outputs are registered together and change on the same edge.
- Status → actuator latency:
  - The debounce counter reaches STABLE_S on the STABLE_S-th tick after the status becomes constant.
  - filt updates on the next edge.
  - The state and outputs update on the edge after that.
- Error latency: status==3 sampled at edge N gives all actuators off and fault=1 after edge N.
- A status glitch shorter than STABLE_S ticks has no effect unless the glitch value is 3.
- reset asserted mid-HEAT/COOL turns relays off after that edge.
- Counter widths are clog2 of their maximum, plus 1. None wrap; all saturate.

## Configuration
- `HVAC_FAULT_LATCH_EN` defined: FAULT is sticky and is left only by reset.
- `HVAC_FAULT_LATCH_EN` undefined: FAULT → REST once filt ≠ 3, i.e. status has held a non-3 value for STABLE_S ticks.

## Structure
- Shared package `hvac_pkg` holds:
  - the state encoding constants (IDLE..FAULT, 3 bits);
  - the status code constants STAT_IDLE, STAT_HEAT, STAT_COOL, STAT_ERR.
- One sub-module, `status_debounce`, implements the candidate/counter/filt logic. It takes `tick` as an input and is parameterised by STABLE_S.
- The prescaler and FSM live in `hvac_actuator`.

## Test plan
Bench parameters: CLK_HZ=4, STABLE_S=2, MIN_ON_S=3, MIN_OFF_S=4, FAN_PURGE_S=2.
- Power-up rest: reset released, status=0 → state_out=3 with all outputs 0 for 4 ticks (16 clk), then state_out=0.
- Minimum run time: status=1 from IDLE → heater_on=fan_on=1 two clocks after the 2nd tick. Drop status to 0 after 1 tick → heater held until run_cnt=3, then REST with fan_on=1 for 2 ticks, fan 0 for 2 more, then IDLE.
- Glitch rejection: status=1 for 1 tick then 0 → no output ever asserts.
- Error override in HEAT: status=3 for one clock → next edge heater/fan 0, fault=1, state_out=4.
  - With the macro defined: stays in FAULT until reset.
  - Without the macro: enters REST after 2 stable ticks of status=0.
- Heat to cool: status 1, then 2 after heating → HEAT→REST(4 ticks)→IDLE→COOL. heater_on and cooler_on are never both 1.
- Reset mid-COOL → cooler_on=0 and state_out=3 after the reset edge, followed by the full 4-tick rest.

Source files
------------

// File: rtl/hvac_pkg.sv
// Shared encodings for the HVAC actuator: FSM state codes and thermostat status codes.
package hvac_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HEAT  = 3'd1,
    COOL  = 3'd2,
    REST  = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [1:0] STAT_IDLE = 2'd0;
  localparam logic [1:0] STAT_HEAT = 2'd1;
  localparam logic [1:0] STAT_COOL = 2'd2;
  localparam logic [1:0] STAT_ERR  = 2'd3;

endpackage

// File: rtl/status_debounce.sv
// Thermostat status debouncer: a value must hold for STABLE_S ticks before it
// reaches filt_o. An error code is passed straight through so that filt_o only
// leaves STAT_ERR once a non-error status has itself been stable.
module status_debounce
  import hvac_pkg::*;
#(
  parameter int unsigned STABLE_S = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_i,
  input  logic [1:0] status_i,
  output logic [1:0] filt_o
);

  localparam int unsigned CW = $clog2(STABLE_S) + 1;

  logic [1:0]    cand_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    filt_q;

  // Track the candidate value, count stable ticks, and publish once stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q <= STAT_IDLE;
      cnt_q  <= '0;
      filt_q <= STAT_IDLE;
    end else begin
      if (status_i != cand_q) begin
        cand_q <= status_i;
        cnt_q  <= '0;
      end else if (tick_i && (cnt_q != CW'(STABLE_S))) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (status_i == STAT_ERR) begin
        filt_q <= STAT_ERR;
      end else if (cnt_q == CW'(STABLE_S)) begin
        filt_q <= cand_q;
      end
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/hvac_actuator.sv
// HVAC actuator controller: one-second prescaler, debounced status, and a
// run/rest FSM driving heater, cooler and fan relays with an immediate error
// bypass into FAULT. Macro HVAC_FAULT_LATCH_EN makes FAULT sticky until reset.
module hvac_actuator
  import hvac_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned STABLE_S    = 3,
  parameter int unsigned MIN_ON_S    = 60,
  parameter int unsigned MIN_OFF_S   = 120,
  parameter int unsigned FAN_PURGE_S = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] status,
  output logic       heater_on,
  output logic       cooler_on,
  output logic       fan_on,
  output logic       fault,
  output logic [2:0] state_out
);

  localparam int unsigned PW = $clog2(CLK_HZ) + 1;
  localparam int unsigned RW = $clog2(MIN_ON_S) + 1;
  localparam int unsigned OW = $clog2(MIN_OFF_S) + 1;

  logic [PW-1:0] presc_q;
  logic          tick;
  logic [1:0]    filt;

  state_t        state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic [OW-1:0] rest_q, rest_d;
  logic          purge_q, purge_d;
  logic          heater_q, heater_d;
  logic          cooler_q, cooler_d;
  logic          fan_q, fan_d;
  logic          fault_q, fault_d;

  // Prescaler: wraps every CLK_HZ cycles, tick is high on the wrap cycle.
  always_ff @(posedge clk) begin
    if (reset || tick) presc_q <= '0;
    else               presc_q <= presc_q + 1'b1;
  end

  assign tick = (presc_q == PW'(CLK_HZ - 1));

  status_debounce #(
    .STABLE_S (STABLE_S)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .tick_i   (tick),
    .status_i (status),
    .filt_o   (filt)
  );

  // State, counters and outputs register together on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= REST;
      run_q    <= '0;
      rest_q   <= '0;
      purge_q  <= 1'b0;
      heater_q <= 1'b0;
      cooler_q <= 1'b0;
      fan_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      rest_q   <= rest_d;
      purge_q  <= purge_d;
      heater_q <= heater_d;
      cooler_q <= cooler_d;
      fan_q    <= fan_d;
      fault_q  <= fault_d;
    end
  end

  // Next state and counters; a raw error code overrides every other decision.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    rest_d  = rest_q;
    purge_d = purge_q;
    case (state_q)
      IDLE: begin
        run_d = '0;
        if (filt == STAT_HEAT)      state_d = HEAT;
        else if (filt == STAT_COOL) state_d = COOL;
      end
      HEAT, COOL: begin
        if (tick && (run_q != RW'(MIN_ON_S))) run_d = run_q + 1'b1;
        if ((run_q == RW'(MIN_ON_S)) &&
            (filt != ((state_q == HEAT) ? STAT_HEAT : STAT_COOL))) begin
          state_d = REST;
          purge_d = 1'b1;
          rest_d  = '0;
        end
      end
      REST: begin
        if (rest_q == OW'(MIN_OFF_S))                 state_d = IDLE;
        else if (tick)                                rest_d  = rest_q + 1'b1;
      end
      FAULT: begin
`ifdef HVAC_FAULT_LATCH_EN
        state_d = FAULT;
`else
        if (filt != STAT_ERR) begin
          state_d = REST;
          purge_d = 1'b0;
          rest_d  = '0;
        end
`endif
      end
      default: begin
        state_d = REST;
        purge_d = 1'b0;
        rest_d  = '0;
      end
    endcase
    if (status == STAT_ERR) state_d = FAULT;
  end

  // Output decode from the next state so outputs land with the state change.
  always_comb begin
    heater_d = 1'b0;
    cooler_d = 1'b0;
    fan_d    = 1'b0;
    fault_d  = 1'b0;
    case (state_d)
      HEAT: begin
        heater_d = 1'b1;
        fan_d    = 1'b1;
      end
      COOL: begin
        cooler_d = 1'b1;
        fan_d    = 1'b1;
      end
      REST:    fan_d   = purge_d && (rest_d < OW'(FAN_PURGE_S));
      FAULT:   fault_d = 1'b1;
      default: ;
    endcase
  end

  assign heater_on = heater_q;
  assign cooler_on = cooler_q;
  assign fan_on    = fan_q;
  assign fault     = fault_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_hvac_actuator.sv
// Directed bench for hvac_actuator with a 4-cycle tick. Edge numbers count
// clock edges since reset release; ticks land on edges 4, 8, 12, ...
module tb_hvac_actuator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] status = 2'd0;
  logic       heater_on, cooler_on, fan_on, fault;
  logic [2:0] state_out;
  logic [6:0] obs;

  // {state_out, heater, cooler, fan, fault}
  localparam logic [6:0] O_IDLE     = {3'd0, 4'b0000};
  localparam logic [6:0] O_HEAT     = {3'd1, 4'b1010};
  localparam logic [6:0] O_COOL     = {3'd2, 4'b0110};
  localparam logic [6:0] O_REST_OFF = {3'd3, 4'b0000};
  localparam logic [6:0] O_REST_FAN = {3'd3, 4'b0010};
  localparam logic [6:0] O_FAULT    = {3'd4, 4'b0001};

  hvac_actuator #(
    .CLK_HZ      (4),
    .STABLE_S    (2),
    .MIN_ON_S    (3),
    .MIN_OFF_S   (4),
    .FAN_PURGE_S (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .status    (status),
    .heater_on (heater_on),
    .cooler_on (cooler_on),
    .fan_on    (fan_on),
    .fault     (fault),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  assign obs = {state_out, heater_on, cooler_on, fan_on, fault};

  int cyc = 0;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  task automatic at_edge(input int n);
    repeat (n - cyc) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    status = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_state", obs, O_REST_OFF);
    reset = 1'b0;
  endtask

  // Heater and cooler must never be driven together.
  always @(negedge clk) begin
    if (!reset) check_eq("excl", {31'b0, heater_on & cooler_on}, 32'd0);
  end

  initial begin
    // Power-up rest followed by a minimum-run heat cycle.
    do_reset();
    at_edge(1);  check_eq("pwr_rest_1", obs, O_REST_OFF);
    at_edge(16); check_eq("pwr_rest_16", obs, O_REST_OFF);
    at_edge(17); check_eq("pwr_idle", obs, O_IDLE);
    status = 2'd1;
    at_edge(25); check_eq("heat_wait", obs, O_IDLE);
    at_edge(26); check_eq("heat_on", obs, O_HEAT);
    status = 2'd0;
    at_edge(36); check_eq("min_on_hold", obs, O_HEAT);
    at_edge(37); check_eq("rest_purge", obs, O_REST_FAN);
    at_edge(43); check_eq("purge_end", obs, O_REST_FAN);
    at_edge(44); check_eq("purge_off", obs, O_REST_OFF);
    at_edge(52); check_eq("rest_last", obs, O_REST_OFF);
    at_edge(53); check_eq("rest_idle", obs, O_IDLE);

    // One-tick glitch of heat request is ignored.
    do_reset();
    at_edge(17); check_eq("glitch_idle0", obs, O_IDLE);
    status = 2'd1;
    for (int e = 18; e <= 40; e++) begin
      at_edge(e);
      check_eq("glitch", obs, O_IDLE);
      if (e == 20) status = 2'd0;
    end

    // Single-cycle error while heating.
    do_reset();
    at_edge(17);
    status = 2'd1;
    at_edge(26); check_eq("err_heat", obs, O_HEAT);
    status = 2'd3;
    at_edge(27); check_eq("err_fault", obs, O_FAULT);
    status = 2'd0;
    at_edge(37); check_eq("fault_hold", obs, O_FAULT);
`ifdef HVAC_FAULT_LATCH_EN
    at_edge(38); check_eq("fault_latch", obs, O_FAULT);
    at_edge(60); check_eq("fault_latch_late", obs, O_FAULT);
    do_reset();
    at_edge(1);  check_eq("fault_cleared", obs, O_REST_OFF);
`else
    at_edge(38); check_eq("fault_exit", obs, O_REST_OFF);
    at_edge(52); check_eq("fault_rest", obs, O_REST_OFF);
    at_edge(53); check_eq("fault_idle", obs, O_IDLE);
`endif

    // Heat to cool through REST and IDLE, then reset mid-cool.
    do_reset();
    at_edge(17);
    status = 2'd1;
    at_edge(26); check_eq("hc_heat", obs, O_HEAT);
    status = 2'd2;
    at_edge(36); check_eq("hc_heat_hold", obs, O_HEAT);
    at_edge(37); check_eq("hc_rest", obs, O_REST_FAN);
    at_edge(52); check_eq("hc_rest_last", obs, O_REST_OFF);
    at_edge(53); check_eq("hc_idle", obs, O_IDLE);
    at_edge(54); check_eq("hc_cool", obs, O_COOL);
    at_edge(56);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_mid_cool", obs, O_REST_OFF);
    reset = 1'b0;
    at_edge(16); check_eq("rst_rest_16", obs, O_REST_OFF);
    at_edge(17); check_eq("rst_idle", obs, O_IDLE);
    at_edge(18); check_eq("rst_cool", obs, O_COOL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
